// File: rtl/attack2_hit_resolver.sv
// Per-frame projectile-vs-enemy hit resolver: serially scans enemy boxes, damages the
// lowest-index overlapping live enemy and flags the hit back to the projectile block.
module attack2_hit_resolver #(
  parameter int          NUM_ENEMY  = 4,
  parameter int          PROJ_SIZE  = 25,
  parameter int          ENEMY_SIZE = 24,
  parameter logic [7:0]  MAX_HP     = 8'd20,
  parameter logic [7:0]  DMG_BASE   = 8'd4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   game_frame_clk_rising_edge,
  input  logic                   Obj_On,
  input  logic [8:0]             Obj_X_Pos,
  input  logic [8:0]             Obj_Y_Pos,
  input  logic [9*NUM_ENEMY-1:0] Enemy_X,
  input  logic [9*NUM_ENEMY-1:0] Enemy_Y,
  input  logic [NUM_ENEMY-1:0]   Enemy_Spawn,
  input  logic [3:0]             Game_Level,
  output logic                   One_Enemy_Is_Attacked2,
  output logic [2:0]             Hit_Index,
  output logic [8*NUM_ENEMY-1:0] Enemy_HP,
  output logic [NUM_ENEMY-1:0]   Enemy_Alive,
  output logic [NUM_ENEMY-1:0]   Enemy_Killed,
  output logic                   Busy
);

  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;

  state_t                          r_state;
  logic [8:0]                      r_px, r_py;
  logic [2:0]                      r_idx;
  logic                            r_flag;
  logic [2:0]                      r_hit_idx;
  logic [NUM_ENEMY-1:0][7:0]       r_hp;
  logic [NUM_ENEMY-1:0]            r_killed;

  logic [8:0] w_ex, w_ey;
  logic       w_sel_alive;
  logic       w_ovl_x, w_ovl_y, w_hit;
  logic [7:0] w_dmg;

  always_comb begin
    for (int i = 0; i < NUM_ENEMY; i++) Enemy_Alive[i] = (r_hp[i] != 8'd0);
  end

  // A spawn pulse on the slot under test counts as alive in that same cycle.
  always_comb begin
    w_ex        = '0;
    w_ey        = '0;
    w_sel_alive = 1'b0;
    for (int i = 0; i < NUM_ENEMY; i++) begin
      if (r_idx == 3'(i)) begin
        w_ex        = Enemy_X[9*i +: 9];
        w_ey        = Enemy_Y[9*i +: 9];
        w_sel_alive = Enemy_Alive[i] | Enemy_Spawn[i];
      end
    end
  end

  assign w_ovl_x = ({1'b0, r_px} < ({1'b0, w_ex} + 10'(ENEMY_SIZE))) &&
                   ({1'b0, w_ex} < ({1'b0, r_px} + 10'(PROJ_SIZE)));
  assign w_ovl_y = ({1'b0, r_py} < ({1'b0, w_ey} + 10'(ENEMY_SIZE))) &&
                   ({1'b0, w_ey} < ({1'b0, r_py} + 10'(PROJ_SIZE)));
  assign w_hit   = w_sel_alive && w_ovl_x && w_ovl_y;
  assign w_dmg   = DMG_BASE + {4'b0, Game_Level};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_px      <= '0;
      r_py      <= '0;
      r_idx     <= '0;
      r_flag    <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      // Frame edge clears the flag; a scan started on the same edge still runs.
      if (game_frame_clk_rising_edge) r_flag <= 1'b0;
      case (r_state)
        IDLE: begin
          if (game_frame_clk_rising_edge && Obj_On) begin
            r_px    <= Obj_X_Pos;
            r_py    <= Obj_Y_Pos;
            r_idx   <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_hit)                           r_state <= APPLY;
          else if (r_idx == 3'(NUM_ENEMY - 1)) r_state <= IDLE;
          else                                 r_idx   <= r_idx + 3'd1;
        end
        APPLY: begin
          r_hit_idx <= r_idx;
          r_flag    <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_ENEMY; i++) r_hp[i] <= MAX_HP;
      r_killed <= '0;
    end else begin
      r_killed <= '0;
      for (int i = 0; i < NUM_ENEMY; i++) begin
        if (Enemy_Spawn[i]) begin
          r_hp[i] <= MAX_HP;
        end else if (r_state == APPLY && r_idx == 3'(i)) begin
          r_hp[i]     <= (r_hp[i] <= w_dmg) ? 8'd0 : r_hp[i] - w_dmg;
          r_killed[i] <= (r_hp[i] != 8'd0) && (r_hp[i] <= w_dmg);
        end
      end
    end
  end

  assign One_Enemy_Is_Attacked2 = r_flag;
  assign Hit_Index              = r_hit_idx;
  assign Enemy_HP               = r_hp;
  assign Enemy_Killed           = r_killed;
  assign Busy                   = (r_state != IDLE);

endmodule

// File: tb/tb_attack2_hit_resolver.sv
// Directed table-driven bench for attack2_hit_resolver plus hand-written timing,
// kill, spawn and reset sequences.
module tb_attack2_hit_resolver;

  localparam int N = 4;
  localparam logic [8:0] F = 9'd400;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          game_frame_clk_rising_edge = 1'b0;
  logic          Obj_On = 1'b0;
  logic [8:0]    Obj_X_Pos = '0, Obj_Y_Pos = '0;
  logic [N-1:0][8:0] ex = '0, ey = '0;
  logic [N-1:0]  Enemy_Spawn = '0;
  logic [3:0]    Game_Level = '0;
  logic          One_Enemy_Is_Attacked2;
  logic [2:0]    Hit_Index;
  logic [8*N-1:0] Enemy_HP;
  logic [N-1:0]  Enemy_Alive, Enemy_Killed;
  logic          Busy;

  attack2_hit_resolver #(.NUM_ENEMY(N)) dut (
    .Clk(Clk), .Reset(Reset),
    .game_frame_clk_rising_edge(game_frame_clk_rising_edge),
    .Obj_On(Obj_On), .Obj_X_Pos(Obj_X_Pos), .Obj_Y_Pos(Obj_Y_Pos),
    .Enemy_X(ex), .Enemy_Y(ey), .Enemy_Spawn(Enemy_Spawn), .Game_Level(Game_Level),
    .One_Enemy_Is_Attacked2(One_Enemy_Is_Attacked2), .Hit_Index(Hit_Index),
    .Enemy_HP(Enemy_HP), .Enemy_Alive(Enemy_Alive), .Enemy_Killed(Enemy_Killed),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0, n_fail = 0;
  int kill_cnt [N];
  initial for (int i = 0; i < N; i++) kill_cnt[i] = 0;
  always @(negedge Clk) for (int i = 0; i < N; i++) if (Enemy_Killed[i] === 1'b1) kill_cnt[i]++;

  typedef struct {
    logic          on;
    logic [8:0]    ox, oy;
    logic [35:0]   vx, vy;
    logic [3:0]    lvl;
    logic          hit;
    logic [2:0]    idx;
    logic [31:0]   hp;
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; tick(); Reset = 1'b0;
  endtask

  task automatic frame();
    game_frame_clk_rising_edge = 1'b1; tick(); game_frame_clk_rising_edge = 1'b0;
  endtask

  function automatic logic [3:0] alive_of(input logic [31:0] hp);
    logic [3:0] a;
    for (int i = 0; i < 4; i++) a[i] = (hp[8*i +: 8] != 8'd0);
    return a;
  endfunction

  function automatic vec_t mkv(input logic on, input logic [8:0] ox, oy,
                               input logic [35:0] vx, vy, input logic [3:0] lvl,
                               input logic hit, input logic [2:0] idx, input logic [31:0] hp);
    vec_t v;
    v.on = on; v.ox = ox; v.oy = oy; v.vx = vx; v.vy = vy; v.lvl = lvl;
    v.hit = hit; v.idx = idx; v.hp = hp;
    return v;
  endfunction

  initial begin
    vt[0] = mkv(1, 100, 100, {F, 9'd110, F, F}, {F, 9'd105, F, F}, 0, 1, 2, 32'h14101414);
    vt[1] = mkv(1, 100, 100, {9'd90, F, 9'd105, F}, {9'd95, F, 9'd110, F}, 3, 1, 1, 32'h14140D14);
    vt[2] = mkv(1, 100, 100, {F, F, F, 9'd125}, {F, F, F, 9'd100}, 0, 0, 0, 32'h14141414);
    vt[3] = mkv(1, 100, 100, {F, F, F, 9'd124}, {F, F, F, 9'd100}, 0, 1, 0, 32'h14141410);
    vt[4] = mkv(1, 100, 100, {9'd100, F, F, F}, {9'd125, F, F, F}, 0, 0, 0, 32'h14141414);
    vt[5] = mkv(1, 100, 100, {9'd100, F, F, F}, {9'd124, F, F, F}, 15, 1, 3, 32'h01141414);
    vt[6] = mkv(1, 100, 100, {F, F, F, 9'd76}, {F, F, F, 9'd100}, 0, 0, 0, 32'h14141414);
    vt[7] = mkv(1, 100, 100, {F, F, F, 9'd77}, {F, F, F, 9'd100}, 2, 1, 0, 32'h1414140E);
    vt[8] = mkv(1, 500, 500, {F, 9'd490, F, F}, {F, 9'd495, F, F}, 1, 1, 2, 32'h140F1414);
    vt[9] = mkv(0, 100, 100, {F, F, F, 9'd100}, {F, F, F, 9'd100}, 0, 0, 0, 32'h14141414);

    // Reset state
    tick(); tick(); Reset = 1'b0;
    chk("rst_flag", 32'(One_Enemy_Is_Attacked2), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_hitidx", 32'(Hit_Index), 0);
    chk("rst_hp", Enemy_HP, 32'h14141414);
    chk("rst_alive", 32'(Enemy_Alive), 32'hF);
    chk("rst_killed", 32'(Enemy_Killed), 0);

    // Frame edge with projectile hidden is ignored
    Obj_X_Pos = 100; Obj_Y_Pos = 100; ex = {F, F, F, 9'd100}; ey = {F, F, F, 9'd100};
    Obj_On = 0; frame();
    chk("off_busy", 32'(Busy), 0);
    repeat (6) tick();
    chk("off_flag", 32'(One_Enemy_Is_Attacked2), 0);
    chk("off_hp", Enemy_HP, 32'h14141414);

    // Table
    for (int i = 0; i < 10; i++) begin
      do_reset();
      Obj_On = vt[i].on; Obj_X_Pos = vt[i].ox; Obj_Y_Pos = vt[i].oy;
      ex = vt[i].vx; ey = vt[i].vy; Game_Level = vt[i].lvl;
      frame();
      repeat (6) tick();
      chk($sformatf("v%0d_flag", i), 32'(One_Enemy_Is_Attacked2), 32'(vt[i].hit));
      if (vt[i].hit) chk($sformatf("v%0d_idx", i), 32'(Hit_Index), 32'(vt[i].idx));
      chk($sformatf("v%0d_hp", i), Enemy_HP, vt[i].hp);
      chk($sformatf("v%0d_alive", i), 32'(Enemy_Alive), 32'(alive_of(vt[i].hp)));
    end

    // Latency and flag hold/clear
    do_reset();
    Obj_On = 1; Obj_X_Pos = 100; Obj_Y_Pos = 100; Game_Level = 0;
    ex = {F, 9'd110, F, F}; ey = {F, 9'd105, F, F};
    frame();
    chk("lat_busy", 32'(Busy), 1);
    repeat (3) tick();
    chk("lat_early", 32'(One_Enemy_Is_Attacked2), 0);
    tick();
    chk("lat_flag", 32'(One_Enemy_Is_Attacked2), 1);
    chk("lat_idx", 32'(Hit_Index), 2);
    chk("lat_hp2", 32'(Enemy_HP[23:16]), 16);
    repeat (3) tick();
    chk("hold_flag", 32'(One_Enemy_Is_Attacked2), 1);
    Obj_On = 0; frame();
    chk("clr_flag", 32'(One_Enemy_Is_Attacked2), 0);
    chk("clr_busy", 32'(Busy), 0);
    Obj_On = 1; frame(); repeat (5) tick();
    chk("again_hp2", 32'(Enemy_HP[23:16]), 12);
    frame();
    chk("prio_clr", 32'(One_Enemy_Is_Attacked2), 0);
    chk("prio_busy", 32'(Busy), 1);
    repeat (5) tick();
    chk("prio_flag", 32'(One_Enemy_Is_Attacked2), 1);
    chk("prio_hp2", 32'(Enemy_HP[23:16]), 8);

    // Kill at level 15, pass-through of dead slot, revival during scan
    do_reset();
    Game_Level = 15; ex = {F, F, 9'd100, F}; ey = {F, F, 9'd100, F};
    begin
      int k0;
      k0 = kill_cnt[1];
      frame(); repeat (6) tick();
      chk("kill_hp1a", 32'(Enemy_HP[15:8]), 1);
      chk("kill_nopulse", 32'(kill_cnt[1] - k0), 0);
      frame(); repeat (6) tick();
      chk("kill_hp1b", 32'(Enemy_HP[15:8]), 0);
      chk("kill_alive", 32'(Enemy_Alive), 32'hD);
      chk("kill_pulse", 32'(kill_cnt[1] - k0), 1);
      frame(); repeat (6) tick();
      chk("dead_nohit", 32'(One_Enemy_Is_Attacked2), 0);
      ex = {F, 9'd110, 9'd100, F}; ey = {F, 9'd100, 9'd100, F};
      frame(); repeat (6) tick();
      chk("pass_idx", 32'(Hit_Index), 2);
      chk("pass_hp", Enemy_HP, 32'h14010014);
      chk("pass_once", 32'(kill_cnt[1] - k0), 1);
      ex = {F, F, 9'd100, F}; ey = {F, F, 9'd100, F};
      frame();
      Enemy_Spawn = 4'b0010; tick(); Enemy_Spawn = '0;
      repeat (5) tick();
      chk("revive_flag", 32'(One_Enemy_Is_Attacked2), 1);
      chk("revive_idx", 32'(Hit_Index), 1);
      chk("revive_hp1", 32'(Enemy_HP[15:8]), 1);
    end

    // Spawn in the APPLY cycle that would kill slot 0
    do_reset();
    Game_Level = 15; ex = {F, F, F, 9'd100}; ey = {F, F, F, 9'd100};
    frame(); repeat (6) tick();
    chk("sp_pre", 32'(Enemy_HP[7:0]), 1);
    begin
      int k0;
      k0 = kill_cnt[0];
      frame(); tick();
      Enemy_Spawn = 4'b0001; tick(); Enemy_Spawn = '0;
      chk("sp_hp0", 32'(Enemy_HP[7:0]), 20);
      repeat (3) tick();
      chk("sp_nokill", 32'(kill_cnt[0] - k0), 0);
      chk("sp_alive", 32'(Enemy_Alive), 32'hF);
    end

    // Reset mid-scan
    do_reset();
    Game_Level = 0; ex = {F, F, F, 9'd100}; ey = {F, F, F, 9'd100};
    frame(); repeat (6) tick();
    chk("mid_pre", 32'(Enemy_HP[7:0]), 16);
    ex = {9'd100, F, F, F}; ey = {9'd100, F, F, F};
    frame(); tick();
    chk("mid_busy", 32'(Busy), 1);
    do_reset();
    chk("mid_flag", 32'(One_Enemy_Is_Attacked2), 0);
    chk("mid_idle", 32'(Busy), 0);
    repeat (6) tick();
    chk("mid_noflag", 32'(One_Enemy_Is_Attacked2), 0);
    chk("mid_hp", Enemy_HP, 32'h14141414);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/attack2_hit_resolver.md
Name: attack2_hit_resolver

Overview:
- Downstream partner of the X-key projectile block (attack2).
- On every game frame tick while the projectile is displayed, it serially tests the projectile box against each enemy box.
- It resolves at most one hit per frame (lowest enemy index wins) and applies level-scaled damage to that enemy's HP register.
- It drives One_Enemy_Is_Attacked2 back to the projectile block to retire the projectile.

Parameters:
- NUM_ENEMY, 4, number of enemy slots scanned (1..8).
- PROJ_SIZE, 25, projectile square side in pixels.
- ENEMY_SIZE, 24, enemy square side in pixels.
- MAX_HP, 8'd20, HP loaded at reset and on spawn.
- DMG_BASE, 8'd4, damage at Game_Level 0.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high reset.
- game_frame_clk_rising_edge  in  1  one-Clk pulse per game frame.
- Obj_On  in  1  projectile displayed (from attack2).
- Obj_X_Pos, Obj_Y_Pos  in  9 each  projectile top-left.
- Enemy_X, Enemy_Y  in  9*NUM_ENEMY each  packed enemy top-left coordinates; slot i is bits [9i+8:9i].
- Enemy_Spawn  in  NUM_ENEMY  per-slot one-Clk pulse that restores HP to MAX_HP.
- Game_Level  in  4  current level.
- One_Enemy_Is_Attacked2  out  1  hit flag to attack2.
- Hit_Index  out  3  slot of the last resolved hit.
- Enemy_HP  out  8*NUM_ENEMY  packed per-slot HP.
- Enemy_Alive  out  NUM_ENEMY  bit i = (HP[i] != 0).
- Enemy_Killed  out  NUM_ENEMY  one-Clk pulse when HP[i] reaches 0.
- Busy  out  1  FSM not in IDLE.

Behaviour:
Reset values:
- One_Enemy_Is_Attacked2=0, Hit_Index=0, Enemy_Killed=0, Busy=0.
- All HP=MAX_HP, so all Enemy_Alive=1.
- FSM=IDLE.
- Reset mid-scan aborts the scan immediately; no damage is applied.

FSM states: IDLE, SCAN, APPLY.
- IDLE: when game_frame_clk_rising_edge & Obj_On, snapshot Obj_X_Pos/Obj_Y_Pos (pre-move values) into internal regs, set idx=0, go to SCAN. A frame edge with Obj_On=0 is ignored.
- SCAN: one slot per Clk. Hit when slot idx is alive AND the boxes overlap:
  - PX < EX+ENEMY_SIZE AND EX < PX+PROJ_SIZE, and the same test on Y.
  - All sums are computed at 10 bits; there is no 9-bit wrap.
  - On hit: latch idx, go to APPLY.
  - No hit and idx==NUM_ENEMY-1: go to IDLE with no outputs changed.
  - Otherwise idx+1.
- APPLY (one Clk):
  - dmg = DMG_BASE + {4'b0,Game_Level}.
  - HP[idx] = (HP[idx] <= dmg) ? 0 : HP[idx]-dmg (saturating at 0).
  - Pulse Enemy_Killed[idx] if the new HP is 0 and the old HP was nonzero.
  - Set Hit_Index=idx and One_Enemy_Is_Attacked2=1.
  - Return to IDLE.

Latency:
- Frame edge at cycle t, slot k tested at cycle t+1+k.
- If slot k hits, APPLY is at t+2+k and the outputs are visible at t+3+k.
- Worst case (k=NUM_ENEMY-1) is NUM_ENEMY+3 Clk, far below a frame period.

One_Enemy_Is_Attacked2 hold rule:
- Holds 1 until the next game_frame_clk_rising_edge, then clears on that edge.
- This lets attack2 clear its step counter at that edge.
- The clear has priority over any new scan starting on the same edge; that scan still runs.

Other rules:
- A frame edge while Busy is ignored.
- Spawn vs damage on the same slot in the same Clk: spawn wins, HP=MAX_HP, no Killed pulse.
- Spawn on any slot during SCAN takes effect immediately; that slot is tested with its new alive state if not yet scanned.
- Dead slots are never hit, so a projectile passes through them.
- Multiple overlapping enemies: only the lowest index takes damage.

Test Plan:
- Reset, then frame edge with Obj_On=0 -> Busy stays 0; all HP=20, Enemy_Alive=4'b1111.
- Obj (100,100), enemy2 at (110,105), others far, level 0, frame edge at t -> One_Enemy_Is_Attacked2=1 at t+5, Hit_Index=2, HP[2]=16; flag clears on the next frame edge.
- Enemies 1 and 3 both overlap, level 3 -> only HP[1] drops 20->13; HP[3]=20.
- Edge adjacency: obj X=100, enemy X=125 -> no hit; enemy X=124 -> hit.
- Level 15 (dmg 19): HP 20 -> 1, then the next hit -> 0. Enemy_Killed[k] pulses once; Alive[k]=0; later overlaps with slot k give no hit.
- Enemy_Spawn[0] asserted in the APPLY cycle that would damage slot 0 -> HP[0]=20, no Killed pulse. Separately, Reset asserted mid-SCAN -> no flag, all HP=20.
